// File: rtl/stdp_weight_updater.sv
`default_nettype none
// ============================================================================
//  Module      : stdp_weight_updater
//  Description : Timestamps pre/post-synaptic spikes on apply strobes, forms
//                spike-pair intervals and applies a piecewise-linear STDP
//                weight change (LTP: b1 - m1*dt, LTD: b2 - m2*dt) to one
//                saturating synaptic weight through a 4-state FSM.
//                Optional debug outputs (last_dw, update_count) are built
//                when the macro STDP_DEBUG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdp_weight_updater #(
    parameter int N      = 32,
    parameter int Q      = 16,
    parameter int T      = 16,
    parameter int WINDOW = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         apply,
    input  logic         enable_stdp,
    input  logic [T-1:0] timestep,
    input  logic         pre_spike,
    input  logic         post_spike,
    input  logic         load_weight,
    input  logic [N-1:0] weight_init,
    input  logic [N-1:0] m1,
    input  logic [N-1:0] b1,
    input  logic [N-1:0] m2,
    input  logic [N-1:0] b2,
    input  logic [N-1:0] w_min,
    input  logic [N-1:0] w_max,
    output logic [N-1:0] weight,
    output logic         update_valid,
    output logic         busy,
    output logic         overflow
`ifdef STDP_DEBUG_EN
    ,
    output logic [N-1:0] last_dw,
    output logic [15:0]  update_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELTA = 2'd1,
        S_MULT  = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    localparam logic [T-1:0] WIN_T = T'(WINDOW);

    state_t         state_q, state_d;

    // Spike timestamps and pair bookkeeping
    logic [T-1:0]   t_pre_q, t_post_q;
    logic           pre_valid_q, post_valid_q;
    logic [T-1:0]   dt_ltp_q, dt_ltd_q;
    logic           pend_ltp_q, pend_ltp_d;
    logic           pend_ltd_q, pend_ltd_d;
    logic           overflow_q, overflow_d;

    // Update datapath
    logic           sel_ltd_q;
    logic [T-1:0]   dt_q;
    logic [N-1:0]   dt_fx_q;
    logic [N-1:0]   prod_q;
    logic [N-1:0]   weight_q, weight_d;
    logic           update_valid_q, update_valid_d;

    // Combinational helpers
    logic           take_ltp, take_ltd;
    logic           cap_ltp, cap_ltd;
    logic [N-1:0]   dt_wide;
    logic [N-1:0]   m_sel, b_sel;
    logic [2*N-1:0] m_ext, dt_fx_ext, prod_full;
    logic [N-1:0]   dw_raw, dw_pos;
    logic [N:0]     w_ext, dw_ext, cand;
    logic [N-1:0]   w_clamped;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; IDLE picks a pending pair (LTP first) and consumes it
    always_comb begin
        state_d  = state_q;
        take_ltp = 1'b0;
        take_ltd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_ltp_q) begin
                    take_ltp = 1'b1;
                    state_d  = S_DELTA;
                end else if (pend_ltd_q) begin
                    take_ltd = 1'b1;
                    state_d  = S_DELTA;
                end
            end
            S_DELTA: begin
                if (dt_q > WIN_T) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_MULT:  state_d = S_APPLY;
            S_APPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pair detection; simultaneous pre+post only refreshes timestamps
    always_comb begin
        cap_ltp = apply && post_spike && !pre_spike && enable_stdp && pre_valid_q;
        cap_ltd = apply && pre_spike && !post_spike && enable_stdp && post_valid_q;

        pend_ltp_d = pend_ltp_q;
        if (take_ltp) begin
            pend_ltp_d = 1'b0;
        end
        if (cap_ltp) begin
            pend_ltp_d = 1'b1;
        end

        pend_ltd_d = pend_ltd_q;
        if (take_ltd) begin
            pend_ltd_d = 1'b0;
        end
        if (cap_ltd) begin
            pend_ltd_d = 1'b1;
        end

        // A new pair lost over an unconsumed one is recorded even on a load
        overflow_d = load_weight ? 1'b0 : overflow_q;
        if ((cap_ltp && pend_ltp_q && !take_ltp) ||
            (cap_ltd && pend_ltd_q && !take_ltd)) begin
            overflow_d = 1'b1;
        end
    end

    // Timestamp capture, interval formation and pending flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_pre_q      <= '0;
            t_post_q     <= '0;
            pre_valid_q  <= 1'b0;
            post_valid_q <= 1'b0;
            dt_ltp_q     <= '0;
            dt_ltd_q     <= '0;
            pend_ltp_q   <= 1'b0;
            pend_ltd_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (apply && pre_spike) begin
                t_pre_q     <= timestep;
                pre_valid_q <= 1'b1;
            end
            if (apply && post_spike) begin
                t_post_q     <= timestep;
                post_valid_q <= 1'b1;
            end
            // Modulo-2^T subtraction keeps intervals correct across wrap
            if (cap_ltp) begin
                dt_ltp_q <= timestep - t_pre_q;
            end
            if (cap_ltd) begin
                dt_ltd_q <= timestep - t_post_q;
            end
            pend_ltp_q <= pend_ltp_d;
            pend_ltd_q <= pend_ltd_d;
            overflow_q <= overflow_d;
        end
    end

    // Slope multiply and delta formation with clamp-to-zero and saturation
    always_comb begin
        dt_wide   = {{(N-T){1'b0}}, dt_q};
        m_sel     = sel_ltd_q ? m2 : m1;
        b_sel     = sel_ltd_q ? b2 : b1;
        m_ext     = {{N{m_sel[N-1]}}, m_sel};
        dt_fx_ext = {{N{dt_fx_q[N-1]}}, dt_fx_q};
        prod_full = m_ext * dt_fx_ext;

        dw_raw = b_sel - prod_q;
        dw_pos = dw_raw[N-1] ? '0 : dw_raw;

        // One guard bit so weight +/- dw cannot wrap before the clamp
        w_ext  = {weight_q[N-1], weight_q};
        dw_ext = {1'b0, dw_pos};
        cand   = sel_ltd_q ? (w_ext - dw_ext) : (w_ext + dw_ext);

        if ($signed(cand) > $signed({w_max[N-1], w_max})) begin
            w_clamped = w_max;
        end else if ($signed(cand) < $signed({w_min[N-1], w_min})) begin
            w_clamped = w_min;
        end else begin
            w_clamped = cand[N-1:0];
        end
    end

    // Weight write: a load overrides an STDP write landing on the same edge
    always_comb begin
        weight_d       = weight_q;
        update_valid_d = 1'b0;
        if (load_weight) begin
            weight_d = weight_init;
        end else if (state_q == S_APPLY) begin
            weight_d       = w_clamped;
            update_valid_d = 1'b1;
        end
    end

    // Datapath pipeline registers advanced by the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_ltd_q      <= 1'b0;
            dt_q           <= '0;
            dt_fx_q        <= '0;
            prod_q         <= '0;
            weight_q       <= '0;
            update_valid_q <= 1'b0;
        end else begin
            if (take_ltp) begin
                sel_ltd_q <= 1'b0;
                dt_q      <= dt_ltp_q;
            end else if (take_ltd) begin
                sel_ltd_q <= 1'b1;
                dt_q      <= dt_ltd_q;
            end
            if (state_q == S_DELTA) begin
                dt_fx_q <= dt_wide << Q;
            end
            if (state_q == S_MULT) begin
                prod_q <= N'(prod_full >> Q);
            end
            weight_q       <= weight_d;
            update_valid_q <= update_valid_d;
        end
    end

`ifdef STDP_DEBUG_EN
    logic [N-1:0] last_dw_q;
    logic [15:0]  update_count_q;

    // Debug record of the applied delta and number of STDP updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dw_q      <= '0;
            update_count_q <= '0;
        end else if (update_valid_d) begin
            last_dw_q      <= sel_ltd_q ? (~dw_pos + 1'b1) : dw_pos;
            update_count_q <= update_count_q + 16'd1;
        end
    end

    assign last_dw      = last_dw_q;
    assign update_count = update_count_q;
`endif

    assign weight       = weight_q;
    assign update_valid = update_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stdp_weight_updater.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stdp_weight_updater
//  Description : Self-checking bench for stdp_weight_updater: directed pairs
//                plus randomized spike traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stdp_weight_updater;

    localparam int N      = 32;
    localparam int T      = 16;
    localparam int WINDOW = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         apply = 1'b0, enable_stdp = 1'b0;
    logic [T-1:0] timestep = '0;
    logic         pre_spike = 1'b0, post_spike = 1'b0, load_weight = 1'b0;
    logic [N-1:0] weight_init = '0, m1 = '0, b1 = '0, m2 = '0, b2 = '0;
    logic [N-1:0] w_min = '0, w_max = '0;
    logic [N-1:0] weight;
    logic         update_valid, busy, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stdp_weight_updater #(.N(N), .Q(16), .T(T), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .apply(apply), .enable_stdp(enable_stdp),
        .timestep(timestep), .pre_spike(pre_spike), .post_spike(post_spike),
        .load_weight(load_weight), .weight_init(weight_init),
        .m1(m1), .b1(b1), .m2(m2), .b2(b2), .w_min(w_min), .w_max(w_max),
        .weight(weight), .update_valid(update_valid), .busy(busy),
        .overflow(overflow)
    );

    // ---------------- behavioural model ----------------
    int m_w;                       // weight
    bit m_uv, m_ovf;
    int m_tpre, m_tpost;
    bit m_prev, m_postv;
    int m_dt_ltp, m_dt_ltd;
    bit m_pl, m_pd;                // pending pairs
    int m_cnt;                     // edges left in the current job (0 = idle)
    bit m_skip, m_ltd;
    int m_jdt;

    always @(posedge clk or negedge rst) begin : mdl
        bit     upd;
        int     ts, prod, dw;
        longint cand;
        if (!rst) begin
            m_w = 0; m_uv = 0; m_ovf = 0; m_tpre = 0; m_tpost = 0;
            m_prev = 0; m_postv = 0; m_dt_ltp = 0; m_dt_ltd = 0;
            m_pl = 0; m_pd = 0; m_cnt = 0; m_skip = 0; m_ltd = 0; m_jdt = 0;
        end else begin
            upd = 0;
            ts  = int'(timestep);
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0 && !m_skip) begin
                    // ((dt<<16)*m)>>>16 equals m*dt, kept to 32 bits
                    prod = int'(longint'(m_ltd ? $signed(m2) : $signed(m1)) * longint'(m_jdt));
                    dw   = (m_ltd ? $signed(b2) : $signed(b1)) - prod;
                    if (dw < 0) dw = 0;
                    cand = m_ltd ? longint'(m_w) - longint'(dw) : longint'(m_w) + longint'(dw);
                    if (cand > longint'($signed(w_max)))      cand = longint'($signed(w_max));
                    else if (cand < longint'($signed(w_min))) cand = longint'($signed(w_min));
                    m_w = int'(cand);
                    upd = 1;
                end
            end else if (m_pl || m_pd) begin
                m_ltd  = !m_pl;
                m_jdt  = m_pl ? m_dt_ltp : m_dt_ltd;
                if (m_pl) m_pl = 0; else m_pd = 0;
                m_skip = (m_jdt > WINDOW);
                m_cnt  = m_skip ? 1 : 3;
            end
            if (load_weight) begin
                m_w = int'(weight_init); m_ovf = 0; upd = 0;
            end
            if (apply) begin
                if (pre_spike && post_spike) begin
                    m_tpre = ts; m_tpost = ts; m_prev = 1; m_postv = 1;
                end else if (post_spike) begin
                    if (enable_stdp && m_prev) begin
                        if (m_pl) m_ovf = 1;
                        m_dt_ltp = (ts - m_tpre) & 32'hFFFF;
                        m_pl = 1;
                    end
                    m_tpost = ts; m_postv = 1;
                end else if (pre_spike) begin
                    if (enable_stdp && m_postv) begin
                        if (m_pd) m_ovf = 1;
                        m_dt_ltd = (ts - m_tpost) & 32'hFFFF;
                        m_pd = 1;
                    end
                    m_tpre = ts; m_prev = 1;
                end
            end
            m_uv = upd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        chk("weight", weight, m_w);
        chk("update_valid", {31'b0, update_valid}, {31'b0, m_uv});
        chk("busy", {31'b0, busy}, {31'b0, (m_cnt != 0)});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(input bit pr, input bit po, input int ts);
        apply = 1'b1; pre_spike = pr; post_spike = po; timestep = 16'(ts);
        tick();
        apply = 1'b0; pre_spike = 1'b0; post_spike = 1'b0;
    endtask

    task automatic load(input int w);
        weight_init = w; load_weight = 1'b1;
        tick();
        load_weight = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (m_cnt != 0 || m_pl || m_pd); i++) tick();
        checks++;
        if (m_cnt != 0 || m_pl || m_pd) begin
            errors++;
            $display("FAIL idle_wait actual=busy required=idle at %0t", $time);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, tmp;
        #1 rst = 1'b0;
        tick();
        chk("rst_weight", weight, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_uv", {31'b0, update_valid}, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);
        rst = 1'b1;
        tick();

        // LTP
        m1 = 32'h100; b1 = 32'h1000; m2 = 32'h100; b2 = 32'h800;
        w_min = 32'h0; w_max = 32'h7FFF_FFFF; enable_stdp = 1'b1;
        load(32'h0001_0000);
        chk("load_weight", weight, 32'h0001_0000);
        ev(1, 0, 10);
        ev(0, 1, 20);
        repeat (3) tick();
        chk("ltp_pre_edge_w", weight, 32'h0001_0000);
        chk("ltp_pre_edge_uv", {31'b0, update_valid}, 32'h0);
        tick();
        chk("ltp_weight", weight, 32'h0001_0600);
        chk("ltp_uv", {31'b0, update_valid}, 32'h1);
        wait_idle();

        // LTD, then simultaneous pre+post
        ev(0, 1, 30);
        ev(1, 0, 35);
        wait_idle();
        chk("ltd_weight", weight, 32'h0001_0300);
        ev(1, 1, 40);
        repeat (6) tick();
        chk("both_weight", weight, 32'h0001_0300);

        // Window and clamp-to-zero
        ev(1, 0, 100);
        wait_idle();
        ev(0, 1, 2100);
        wait_idle();
        chk("window_weight", weight, 32'h0001_0300);
        b1 = 32'h100;
        ev(1, 0, 3000);
        wait_idle();
        ev(0, 1, 3005);
        repeat (4) tick();
        chk("zero_dw_uv", {31'b0, update_valid}, 32'h1);
        chk("zero_dw_weight", weight, 32'h0001_0300);
        wait_idle();

        // Saturation across timestep wrap
        b1 = 32'h1000; w_max = 32'h0001_0400;
        ev(1, 0, 32'hFFFE);
        wait_idle();
        ev(0, 1, 3);
        wait_idle();
        chk("sat_weight", weight, 32'h0001_0400);
        w_max = 32'h7FFF_FFFF;

        // Overflow: a pending LTP overwritten while the FSM is busy
        ev(1, 0, 200);
        wait_idle();
        ev(0, 1, 210);
        ev(0, 1, 212);
        ev(0, 1, 215);
        chk("ovf_set", {31'b0, overflow}, 32'h1);
        wait_idle();
        chk("ovf_weight", weight, 32'h0001_0B00);
        load(32'h0001_0000);
        chk("ovf_clear", {31'b0, overflow}, 32'h0);

        // LTP priority over LTD when both pend
        ev(0, 1, 300);
        ev(1, 0, 302);
        ev(0, 1, 303);
        repeat (6) tick();
        chk("prio_ltp_uv", {31'b0, update_valid}, 32'h1);
        chk("prio_ltp_w", weight, 32'h0001_0F00);
        repeat (4) tick();
        chk("prio_ltd_uv", {31'b0, update_valid}, 32'h1);
        chk("prio_ltd_w", weight, 32'h0001_0900);
        wait_idle();

        // Randomized traffic
        for (int ph = 0; ph < 6; ph++) begin
            wait_idle();
            m1 = $urandom_range(0, 32'h3FF);
            m2 = $urandom_range(0, 32'h3FF);
            if (ph[0]) m2 = -m2;
            b1 = $urandom_range(0, 32'h40000);
            b2 = $urandom_range(0, 32'h40000);
            tmp = $urandom_range(0, 32'h20000);
            w_min = -tmp;
            w_max = $urandom_range(32'h10000, 32'h30000);
            load($urandom_range(0, 32'h10000));
            ts = $urandom_range(0, 65535);
            for (int c = 0; c < 250; c++) begin
                apply       = ($urandom_range(0, 99) < 40);
                pre_spike   = ($urandom_range(0, 2) == 0);
                post_spike  = ($urandom_range(0, 2) == 0);
                if (apply) ts = (ts + $urandom_range(0, 300)) & 32'hFFFF;
                timestep    = 16'(ts);
                enable_stdp = ($urandom_range(0, 9) != 0);
                load_weight = ($urandom_range(0, 49) == 0);
                weight_init = $urandom_range(0, 32'h18000);
                tick();
            end
            apply = 1'b0; pre_spike = 1'b0; post_spike = 1'b0; load_weight = 1'b0;
        end

        // Reset in the middle of MULT
        wait_idle();
        enable_stdp = 1'b1; m1 = 32'h100; b1 = 32'h2000;
        w_min = 32'h0; w_max = 32'h7FFF_FFFF;
        load(32'h0002_0000);
        ev(1, 0, 500);
        wait_idle();
        ev(0, 1, 510);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_weight", weight, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_uv", {31'b0, update_valid}, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("post_rst_weight", weight, 32'h0);
        load(32'h0002_0000);
        chk("reload_weight", weight, 32'h0002_0000);
        ev(1, 0, 600);
        ev(0, 1, 620);
        repeat (4) tick();
        chk("post_rst_ltp_uv", {31'b0, update_valid}, 32'h1);
        chk("post_rst_ltp_w", weight, 32'h0002_0C00);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
